// File: rtl/warp_call_stack.sv
// warp_call_stack: per-warp return-address stack holding {return PC, active mask} for CALL/RET
module warp_call_stack #(
  parameter int NUM_WARPS = 2,
  parameter int WARP_SIZE = 32,
  parameter int DEPTH = 8,
  parameter int PC_WIDTH = 32,
  localparam int WW = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [1:0]           req_op,
  input  logic [WW-1:0]        req_warp,
  input  logic [PC_WIDTH-1:0]  req_pc,
  input  logic [WARP_SIZE-1:0] req_mask,
  input  logic                 clr_valid,
  input  logic [WW-1:0]        clr_warp,
  output logic                 resp_valid,
  output logic [WW-1:0]        resp_warp,
  output logic [PC_WIDTH-1:0]  resp_pc,
  output logic [WARP_SIZE-1:0] resp_mask,
  output logic [1:0]           resp_status,
  input  logic [WW-1:0]        qry_warp,
  output logic [DW-1:0]        qry_depth,
  output logic [NUM_WARPS-1:0] err_sticky
);
  localparam logic [WW:0] NW = NUM_WARPS[WW:0];
  localparam logic [DW-1:0] DMAX = DEPTH[DW-1:0];
  logic [DW-1:0] sp [NUM_WARPS];
  logic [PC_WIDTH-1:0] ent_pc [NUM_WARPS][DEPTH];
  logic [WARP_SIZE-1:0] ent_mask [NUM_WARPS][DEPTH];
  logic act, hit, full, empty, is_push, is_pop, is_read;
  logic [DW-1:0] cur;
  logic [AW-1:0] top;
  assign qry_depth = sp[qry_warp];
  // decode the incoming request against the target warp's current depth
  always_comb begin
    act = req_valid && req_op != 2'b00 && {1'b0, req_warp} < NW;
    hit = clr_valid && clr_warp == req_warp;
    cur = sp[req_warp];
    full = cur == DMAX;
    empty = cur == '0;
    top = AW'(cur - DW'(1));
    is_push = req_op == 2'b01;
    is_pop = req_op == 2'b10;
    is_read = req_op[1];
  end
  // depth counters and sticky error flags; a clear overrides any request to the same warp
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) sp[w] <= '0;
      err_sticky <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++)
        if (clr_valid && clr_warp == WW'(w)) begin
          sp[w] <= '0;
          err_sticky[w] <= 1'b0;
        end else if (act && req_warp == WW'(w)) begin
          sp[w] <= is_push && !full ? cur + DW'(1) : is_pop && !empty ? cur - DW'(1) : cur;
          if ((is_push && full) || (is_read && empty)) err_sticky[w] <= 1'b1;
        end
    end
  // entry storage is plain flops with no reset; only live slots below sp are ever read
  always_ff @(posedge clk)
    if (act && !hit && is_push && !full) begin
      ent_pc[req_warp][AW'(cur)] <= req_pc;
      ent_mask[req_warp][AW'(cur)] <= req_mask;
    end
  // registered response, one cycle after any non-NOP request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_warp <= '0;
      resp_pc <= '0;
      resp_mask <= '0;
      resp_status <= 2'b00;
    end else begin
      resp_valid <= act;
      if (act) begin
        resp_warp <= req_warp;
        resp_status <= hit ? 2'b11 : is_push ? (full ? 2'b01 : 2'b00) : (empty ? 2'b10 : 2'b00);
        resp_pc <= hit || is_push || empty ? '0 : ent_pc[req_warp][top];
        resp_mask <= hit || is_push || empty ? '0 : ent_mask[req_warp][top];
      end
    end
endmodule
